// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multi-cycle multiply/divide unit and the
// control unit that issues MULT/DIV requests to it.
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL_RUN = 2'd1,
    DIV_RUN = 2'd2
  } md_state_e;

  localparam int WIDTH_DEF = 32;
  localparam int ITER_LAST = 31;

  // funct field encodings shared with the control unit
  localparam logic [5:0] MULT = 6'b011000;
  localparam logic [5:0] DIV  = 6'b011010;

endpackage

// File: rtl/div_restore_step.sv
// One combinational restoring-division step: shift the next dividend bit into
// the partial remainder and subtract the divisor when it fits.
module div_restore_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] divisor,
  input  logic             next_bit,
  output logic [WIDTH-1:0] new_rem,
  output logic             q_bit
);

  logic [WIDTH:0] trial_s;

  // trial subtraction; the result is always below the divisor so WIDTH bits suffice
  always_comb begin
    trial_s = {rem, next_bit};
    if (trial_s >= {1'b0, divisor}) begin
      new_rem = trial_s[WIDTH-1:0] - divisor;
      q_bit   = 1'b1;
    end else begin
      new_rem = trial_s[WIDTH-1:0];
      q_bit   = 1'b0;
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle signed multiply (radix-2 Booth) / restoring divide with HI/LO.
// Optional macro MULTDIV_UNSIGNED_EN adds is_unsigned for MULTU/DIVU.
module mult_div_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef MULTDIV_UNSIGNED_EN
  input  logic             is_unsigned,
`endif
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  md_state_e          state_r, state_nx_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [2*WIDTH:0]   acc_r;
  logic [WIDTH-1:0]   m_r, dvs_r, hi_r, lo_r;
  logic               neg_q_r, neg_r_r, busy_r, done_r, dz_r;
  logic               accept_mul_s, accept_div_s, div_zero_s, step_s, finish_s;
  logic               uns_s, sign_a_s, sign_b_s;
  logic [WIDTH-1:0]   abs_a_s, abs_b_s;
  logic [WIDTH:0]     booth_a_s, booth_m_s, booth_sum_s;
  logic [2*WIDTH:0]   booth_nx_s, div_nx_s, acc_nx_s;
  logic [WIDTH-1:0]   rem_nx_s, quot_s, res_hi_s, res_lo_s;
  logic               q_bit_s;

`ifdef MULTDIV_UNSIGNED_EN
  logic               uns_r;
  assign uns_s = is_unsigned;
`else
  assign uns_s = 1'b0;
`endif

  // operand sign capture and magnitude for the divider
  always_comb begin
    sign_a_s = ~uns_s & a[WIDTH-1];
    sign_b_s = ~uns_s & b[WIDTH-1];
    if (sign_a_s) abs_a_s = -a;
    else          abs_a_s = a;
    if (sign_b_s) abs_b_s = -b;
    else          abs_b_s = b;
  end

  // state register
  always_ff @(posedge clock) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_nx_s;
  end

  // next-state and control strobes
  always_comb begin
    state_nx_s   = state_r;
    accept_mul_s = 1'b0;
    accept_div_s = 1'b0;
    div_zero_s   = 1'b0;
    step_s       = 1'b0;
    finish_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_mult) begin
          accept_mul_s = 1'b1;
          state_nx_s   = MUL_RUN;
        end else if (start_div) begin
          if (b == {WIDTH{1'b0}}) begin
            div_zero_s = 1'b1;
          end else begin
            accept_div_s = 1'b1;
            state_nx_s   = DIV_RUN;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      MUL_RUN, DIV_RUN: begin
        step_s = 1'b1;
        if (cnt_r == LAST_CNT) begin
          finish_s   = 1'b1;
          state_nx_s = IDLE;
        end else begin
          state_nx_s = state_r;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  div_restore_step #(.WIDTH(WIDTH)) u_div_step (
    .rem      (acc_r[2*WIDTH:WIDTH+1]),
    .divisor  (dvs_r),
    .next_bit (acc_r[WIDTH]),
    .new_rem  (rem_nx_s),
    .q_bit    (q_bit_s)
  );

  // iteration datapath; Booth add is one bit wider so a most-negative multiplicand cannot overflow
  always_comb begin
    booth_a_s = {acc_r[2*WIDTH], acc_r[2*WIDTH:WIDTH+1]};
    booth_m_s = {m_r[WIDTH-1], m_r};
    case (acc_r[1:0])
      2'b01:   booth_sum_s = booth_a_s + booth_m_s;
      2'b10:   booth_sum_s = booth_a_s - booth_m_s;
      default: booth_sum_s = booth_a_s;
    endcase
    booth_nx_s = {booth_sum_s, acc_r[WIDTH:1]};
    div_nx_s   = {rem_nx_s, acc_r[WIDTH-1:1], q_bit_s, 1'b0};
    quot_s     = div_nx_s[WIDTH:1];
    if (state_r == MUL_RUN) begin
      acc_nx_s = booth_nx_s;
      res_hi_s = booth_nx_s[2*WIDTH:WIDTH+1];
      res_lo_s = booth_nx_s[WIDTH:1];
`ifdef MULTDIV_UNSIGNED_EN
      // unsigned fix-up: add back each operand's MSB weight into the upper half
      if (uns_r) begin
        res_hi_s = res_hi_s + (m_r[WIDTH-1] ? dvs_r : {WIDTH{1'b0}})
                            + (dvs_r[WIDTH-1] ? m_r : {WIDTH{1'b0}});
      end else begin
        res_hi_s = booth_nx_s[2*WIDTH:WIDTH+1];
      end
`endif
    end else begin
      acc_nx_s = div_nx_s;
      if (neg_q_r) res_lo_s = -quot_s;
      else         res_lo_s = quot_s;
      if (neg_r_r) res_hi_s = -rem_nx_s;
      else         res_hi_s = rem_nx_s;
    end
  end

  // operand latch, iteration, result and pulse registers
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_r   <= {CNT_W{1'b0}};
      acc_r   <= {(2*WIDTH+1){1'b0}};
      m_r     <= {WIDTH{1'b0}};
      dvs_r   <= {WIDTH{1'b0}};
      hi_r    <= {WIDTH{1'b0}};
      lo_r    <= {WIDTH{1'b0}};
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      dz_r    <= 1'b0;
`ifdef MULTDIV_UNSIGNED_EN
      uns_r   <= 1'b0;
`endif
    end else begin
      if (accept_mul_s) begin
        acc_r <= {{WIDTH{1'b0}}, b, 1'b0};
        m_r   <= a;
        dvs_r <= b;
        cnt_r <= {CNT_W{1'b0}};
`ifdef MULTDIV_UNSIGNED_EN
        uns_r <= uns_s;
`endif
      end else if (accept_div_s) begin
        acc_r   <= {{WIDTH{1'b0}}, abs_a_s, 1'b0};
        dvs_r   <= abs_b_s;
        neg_q_r <= sign_a_s ^ sign_b_s;
        neg_r_r <= sign_a_s;
        cnt_r   <= {CNT_W{1'b0}};
      end else if (step_s) begin
        acc_r <= acc_nx_s;
        cnt_r <= finish_s ? {CNT_W{1'b0}} : cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (finish_s) begin
        hi_r <= res_hi_s;
        lo_r <= res_lo_s;
      end
      busy_r <= (state_nx_s != IDLE);
      done_r <= finish_s;
      dz_r   <= div_zero_s;
    end
  end

  assign hi       = hi_r;
  assign lo       = lo_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign div_zero = dz_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: latency, results, pulses,
// divide-by-zero, ignored starts while busy and mid-run reset.
module tb_mult_div_unit;
  import multdiv_pkg::*;

  logic        clock = 1'b0;
  logic        reset, start_mult, start_div;
  logic [31:0] a, b, hi, lo;
  logic        busy, done, div_zero;
`ifdef MULTDIV_UNSIGNED_EN
  logic        is_unsigned = 1'b0;
`endif
  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  mult_div_unit dut (
    .clock       (clock),
    .reset       (reset),
    .start_mult  (start_mult),
    .start_div   (start_div),
    .a           (a),
    .b           (b),
`ifdef MULTDIV_UNSIGNED_EN
    .is_unsigned (is_unsigned),
`endif
    .hi          (hi),
    .lo          (lo),
    .busy        (busy),
    .done        (done),
    .div_zero    (div_zero)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // drive a one-cycle start; returns just after the accepting edge
  task automatic issue(input logic [5:0] funct, input logic [31:0] aa, input logic [31:0] bb);
    a          = aa;
    b          = bb;
    start_mult = (funct == MULT);
    start_div  = (funct == DIV);
    step(1);
    start_mult = 1'b0;
    start_div  = 1'b0;
  endtask

  // bounded wait for done; checks cycles elapsed and how long busy stayed high
  task automatic wait_done(input string tag, input int exp_lat, input int exp_busy);
    int lat = 0;
    int bcnt = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) bcnt++;
      step(1);
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy"}, 32'(bcnt), 32'(exp_busy));
  endtask

  initial begin
    int ndone;
    reset = 1'b1; start_mult = 1'b0; start_div = 1'b0; a = 32'd0; b = 32'd0;
    step(2);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dz", 32'(div_zero), 32'd0);
    reset = 1'b0;

    // 7 * -3 = -21
    issue(MULT, 32'd7, 32'hFFFF_FFFD);
    wait_done("mul_small", ITER_LAST + 1, ITER_LAST + 1);
    check("mul_small_hi", hi, 32'hFFFF_FFFF);
    check("mul_small_lo", lo, 32'hFFFF_FFEB);

    // back-to-back start in the done cycle: INT_MIN * INT_MIN = 2^62
    issue(MULT, 32'h8000_0000, 32'h8000_0000);
    check("b2b_done_pulse", 32'(done), 32'd0);
    check("b2b_busy", 32'(busy), 32'd1);
    wait_done("mul_corner", ITER_LAST + 1, ITER_LAST + 1);
    check("mul_corner_hi", hi, 32'h4000_0000);
    check("mul_corner_lo", lo, 32'h0000_0000);
    step(3);
    check("hold_hi", hi, 32'h4000_0000);
    check("hold_lo", lo, 32'h0000_0000);
    check("hold_done", 32'(done), 32'd0);

    // -7 / 2 = -3 rem -1
    issue(DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_neg", 32, 32);
    check("div_neg_lo", lo, 32'hFFFF_FFFD);
    check("div_neg_hi", hi, 32'hFFFF_FFFF);

    // 7 / -2 = -3 rem 1
    issue(DIV, 32'd7, 32'hFFFF_FFFE);
    wait_done("div_negb", 32, 32);
    check("div_negb_lo", lo, 32'hFFFF_FFFD);
    check("div_negb_hi", hi, 32'h0000_0001);

    // 100 / 7 = 14 rem 2
    issue(DIV, 32'd100, 32'd7);
    wait_done("div_pos", 32, 32);
    check("div_pos_lo", lo, 32'd14);
    check("div_pos_hi", hi, 32'd2);

    // INT_MIN / -1 wraps
    issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf", 32, 32);
    check("div_ovf_lo", lo, 32'h8000_0000);
    check("div_ovf_hi", hi, 32'h0000_0000);

    // divide by zero after preloading 3*5
    issue(MULT, 32'd3, 32'd5);
    wait_done("pre", 32, 32);
    check("pre_lo", lo, 32'd15);
    issue(DIV, 32'd5, 32'd0);
    check("dz_pulse", 32'(div_zero), 32'd1);
    check("dz_done", 32'(done), 32'd0);
    check("dz_busy", 32'(busy), 32'd0);
    check("dz_hi", hi, 32'd0);
    check("dz_lo", lo, 32'd15);
    step(1);
    check("dz_clear", 32'(div_zero), 32'd0);
    check("dz_busy2", 32'(busy), 32'd0);

    // start_div during a multiply is ignored
    issue(MULT, 32'd2, 32'd3);
    step(3);
    a = 32'd9; b = 32'd3; start_div = 1'b1;
    step(1);
    start_div = 1'b0;
    check("ign_busy", 32'(busy), 32'd1);
    wait_done("ign", 28, 28);
    check("ign_hi", hi, 32'd0);
    check("ign_lo", lo, 32'd6);
    step(1);
    check("ign_idle", 32'(busy), 32'd0);

    // reset mid-run aborts without done
    issue(MULT, 32'd12, 32'd12);
    step(9);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_hi", hi, 32'd0);
    check("mrst_lo", lo, 32'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) ndone++;
      step(1);
    end
    check("mrst_no_done", 32'(ndone), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle signed multiply/divide responder for the multicycle MIPS datapath.
- The control FSM issues a one-cycle start (MULT or DIV funct) with operands from regs A/B.
- The unit iterates 32 cycles, writes its internal HI/LO registers, and returns a one-cycle done or div_zero pulse.
- The control FSM waits on done; on div_zero it branches to the exception sequence.

Parameters:
- WIDTH, 32, operand width; hi/lo are WIDTH each; product is 2*WIDTH.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start_mult  in  1  one-cycle request: signed a*b
- start_div  in  1  one-cycle request: signed a/b
- a  in  WIDTH  operand (multiplicand/dividend), sampled on accepted start
- b  in  WIDTH  operand (multiplier/divisor), sampled on accepted start
- hi  out  WIDTH  product[63:32] or remainder
- lo  out  WIDTH  product[31:0] or quotient
- busy  out  1  operation in progress
- done  out  1  one-cycle result-valid pulse
- div_zero  out  1  one-cycle divide-by-zero pulse

Behaviour:
- Reset: clock is `clock`; reset is `reset`, synchronous, active-high.
  - Reset gives hi=0, lo=0, busy=0, done=0, div_zero=0, state=IDLE, counter=0.
  - Reset mid-operation aborts the operation; no done is produced.
- States: IDLE, MUL_RUN, DIV_RUN.
  - done and div_zero are registered pulses, never held longer than one cycle.
- Accept: a start is accepted only in IDLE.
  - Starts seen while busy=1 are ignored; no queueing.
  - If start_mult and start_div are high together, mult wins and div is dropped.
- Multiply, start accepted at edge N:
  - Latch a and b; state becomes MUL_RUN; busy=1; count=0.
  - Radix-2 Booth: edges N+1..N+32 each perform one iteration with a 65-bit arithmetic-right-shift accumulator.
  - At edge N+32: {hi,lo} = signed 64-bit product; done=1 for one cycle; busy=0; return to IDLE.
- Divide, start accepted at edge N with b!=0:
  - Latch |a| and |b| and both signs; state becomes DIV_RUN; busy=1.
  - Restoring division, one quotient bit per edge, edges N+1..N+32.
  - At edge N+32: lo = quotient truncated toward zero; hi = remainder carrying the sign of the dividend; done=1; busy=0; return to IDLE.
  - a=0x80000000, b=0xFFFFFFFF: lo=0x80000000, hi=0 (wraps, no exception).
- Divide by zero (start_div with b==0):
  - No run; at edge N, div_zero=1 for one cycle and done=0.
  - busy stays 0; hi and lo are unchanged.
- Holding and back-to-back:
  - hi/lo change only on completion edges or reset; they hold between operations.
  - A new start is accepted in the same cycle done is high (state is IDLE).
- Fixed latency: result-valid 32 cycles after the start edge; the control FSM must not rely on an earlier result.

Optional Feature:
- Macro: MULTDIV_UNSIGNED_EN.
- Defined:
  - Adds input port is_unsigned (1 bit), sampled with start, supporting MULTU/DIVU.
  - When is_unsigned=1, operands are zero-extended; no sign correction on quotient/remainder; no INT_MIN special case.
  - Divide-by-zero behaviour is identical.
- Undefined: no port; all operations are signed.

Decomposition:
- Package multdiv_pkg holds:
  - state enum {IDLE, MUL_RUN, DIV_RUN};
  - WIDTH_DEF=32 and ITER_LAST=31;
  - funct constants MULT=6'b011000, DIV=6'b011010 shared with the control unit.
- One sub-module, div_restore_step: combinational single restoring step (remainder, divisor, next bit) -> (new remainder, quotient bit).
- Booth step stays inline.

Test Plan:
- Small signed multiply: start_mult, a=7, b=0xFFFFFFFD -> done exactly 32 cycles after the start edge; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for 32 cycles.
- Corner multiply: a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0.
- Signed divide: start_div, a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Overflow divide: a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Divide by zero:
  - Preload hi/lo via 3*5; then start_div b=0 -> div_zero pulse the next cycle, done=0, busy=0, hi=0, lo=15 unchanged.
- Start during busy and mid-run reset:
  - start_mult 2*3, then start_div 9/3 at cycle 5 -> ignored; result hi=0, lo=6.
  - New start_mult, reset at cycle 10 -> busy=0, hi=lo=0, no done.
